// File: rtl/alu_seq_legv8.sv
// Multi-cycle LEGv8 ALU: single-cycle logic/add/shift plus iterative MUL (low half) and UDIV,
// with valid/ready operand handshake and a result register held until the consumer accepts it.
module alu_seq_legv8 #(
  parameter int unsigned WIDTH = 64
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [4:0]       FS,
  input  logic             C0,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] F,
  output logic [3:0]       status
);

  localparam int unsigned SHW = $clog2(WIDTH);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e           state_q;
  logic [WIDTH-1:0] f_q;
  logic [3:0]       status_q;
  logic             is_div_q;
  logic [SHW-1:0]   cnt_q;
  // MUL: acc = partial product, opa = shifted multiplicand, opb = shifted multiplier.
  // UDIV: acc = partial remainder, opa = dividend shifting out / quotient shifting in,
  //       opb = divisor.
  logic [WIDTH-1:0] acc_q;
  logic [WIDTH-1:0] opa_q;
  logic [WIDTH-1:0] opb_q;

  logic [WIDTH-1:0] as_v;
  logic [WIDTH-1:0] bs_v;
  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] comb_f;
  logic             comb_c;
  logic             comb_v;

  logic [WIDTH-1:0] mul_acc;
  logic [WIDTH:0]   rem_sh;
  logic [WIDTH:0]   rem_sub;
  logic             rem_geq;
  logic [WIDTH-1:0] div_acc;
  logic [WIDTH-1:0] div_quo;
  logic [WIDTH-1:0] run_f;

  assign in_ready  = (state_q == StIdle);
  assign out_valid = (state_q == StDone);
  assign F         = f_q;
  assign status    = status_q;

  always_comb begin
    as_v   = FS[0] ? ~A : A;
    bs_v   = FS[1] ? ~B : B;
    sum    = {1'b0, as_v} + {1'b0, bs_v} + {{WIDTH{1'b0}}, C0};
    comb_f = '0;
    comb_c = 1'b0;
    comb_v = 1'b0;
    case (FS[4:2])
      3'b000: comb_f = as_v & bs_v;
      3'b001: comb_f = as_v | bs_v;
      3'b011: comb_f = as_v ^ bs_v;
      3'b010: begin
        comb_f = sum[WIDTH-1:0];
        comb_c = sum[WIDTH];
        comb_v = ~(as_v[WIDTH-1] ^ bs_v[WIDTH-1]) & (sum[WIDTH-1] ^ as_v[WIDTH-1]);
      end
      3'b100: comb_f = A << B[SHW-1:0];
      3'b101: comb_f = A >> B[SHW-1:0];
      default: comb_f = '0;
    endcase
  end

  always_comb begin
    mul_acc = acc_q + (opb_q[0] ? opa_q : '0);
    rem_sh  = {acc_q, opa_q[WIDTH-1]};
    rem_sub = rem_sh - {1'b0, opb_q};
    rem_geq = (rem_sh >= {1'b0, opb_q});
    div_acc = rem_geq ? rem_sub[WIDTH-1:0] : rem_sh[WIDTH-1:0];
    div_quo = {opa_q[WIDTH-2:0], rem_geq};
    // Division by zero still runs the full iteration count, then reports zero.
    if (is_div_q) begin
      run_f = (opb_q == '0) ? '0 : div_quo;
    end else begin
      run_f = mul_acc;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= StIdle;
      f_q      <= '0;
      status_q <= '0;
    end else begin
      case (state_q)
        StIdle: begin
          if (in_valid) begin
            if (FS[4:3] == 2'b11) begin
              state_q  <= StRun;
              is_div_q <= FS[2];
              acc_q    <= '0;
              opa_q    <= A;
              opb_q    <= B;
              cnt_q    <= SHW'(WIDTH - 1);
            end else begin
              state_q  <= StDone;
              f_q      <= comb_f;
              status_q <= {comb_v, comb_c, comb_f[WIDTH-1], comb_f == '0};
            end
          end
        end
        StRun: begin
          cnt_q <= cnt_q - 1'b1;
          if (is_div_q) begin
            acc_q <= div_acc;
            opa_q <= div_quo;
          end else begin
            acc_q <= mul_acc;
            opa_q <= opa_q << 1;
            opb_q <= opb_q >> 1;
          end
          if (cnt_q == '0) begin
            state_q  <= StDone;
            f_q      <= run_f;
            status_q <= {2'b00, run_f[WIDTH-1], run_f == '0};
          end
        end
        StDone: begin
          if (out_ready) begin
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq_legv8.sv
// Scoreboard bench for alu_seq_legv8 at WIDTH=64 and WIDTH=16: a behavioural model pushes
// expected F/status at issue time, per-instance monitors pop and compare on each handshake.
module tb_alu_seq_legv8;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  logic        iv64, ir64, ov64, ordy64, c064;
  logic [63:0] a64, b64, f64;
  logic [4:0]  fs64;
  logic [3:0]  st64;

  logic        iv16, ir16, ov16, ordy16, c016;
  logic [15:0] a16, b16, f16;
  logic [4:0]  fs16;
  logic [3:0]  st16;

  alu_seq_legv8 #(.WIDTH(64)) u_dut64 (
    .clock(clock), .reset(reset), .in_valid(iv64), .in_ready(ir64), .A(a64), .B(b64),
    .FS(fs64), .C0(c064), .out_valid(ov64), .out_ready(ordy64), .F(f64), .status(st64)
  );

  alu_seq_legv8 #(.WIDTH(16)) u_dut16 (
    .clock(clock), .reset(reset), .in_valid(iv16), .in_ready(ir16), .A(a16), .B(b16),
    .FS(fs16), .C0(c016), .out_valid(ov16), .out_ready(ordy16), .F(f16), .status(st16)
  );

  typedef struct packed {
    logic [63:0] f;
    logic [3:0]  st;
  } exp_t;

  exp_t  q64[$];
  exp_t  q16[$];
  string t64[$];
  string t16[$];
  int    n_tests = 0;
  int    n_fail  = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Returns {V,C,N,Z,F} for a WIDTH-w ALU.
  function automatic logic [67:0] model(input logic [63:0] a_in, input logic [63:0] b_in,
                                        input logic [4:0] fs, input logic c0, input int w);
    logic [63:0] mask, a, b, as_v, bs_v, f;
    logic [64:0] sum;
    logic        v, c;
    int          amt;
    mask = (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
    a    = a_in & mask;
    b    = b_in & mask;
    as_v = (fs[0] ? ~a : a) & mask;
    bs_v = (fs[1] ? ~b : b) & mask;
    amt  = int'(b[5:0]) & (w - 1);
    v    = 1'b0;
    c    = 1'b0;
    f    = '0;
    sum  = '0;
    case (fs[4:2])
      3'b000: f = as_v & bs_v;
      3'b001: f = as_v | bs_v;
      3'b011: f = as_v ^ bs_v;
      3'b010: begin
        sum = {1'b0, as_v} + {1'b0, bs_v} + {64'd0, c0};
        f   = sum[63:0] & mask;
        c   = sum[w];
        v   = ~(as_v[w-1] ^ bs_v[w-1]) & (f[w-1] ^ as_v[w-1]);
      end
      3'b100: f = (a << amt) & mask;
      3'b101: f = a >> amt;
      3'b110: f = (a * b) & mask;
      default: f = (b == 64'd0) ? 64'd0 : a / b;
    endcase
    return {v, c, f[w-1], f == 64'd0, f};
  endfunction

  function automatic logic rdy_of(input int w);
    return (w == 64) ? ir64 : ir16;
  endfunction

  function automatic logic vld_of(input int w);
    return (w == 64) ? ov64 : ov16;
  endfunction

  // Issue one op on the w-wide instance and check handshake timing; leaves the DUT in DONE.
  task automatic issue(input int w, input string tag, input logic [63:0] a, input logic [63:0] b,
                       input logic [4:0] fs, input logic c0);
    logic [67:0] m;
    exp_t        e;
    int          waits, lat, busy_bad, exp_lat;
    m       = model(a, b, fs, c0, w);
    e.f     = m[63:0];
    e.st    = m[67:64];
    exp_lat = (fs[4:3] == 2'b11) ? w + 1 : 1;
    waits   = 0;
    while (!rdy_of(w) && waits < 200) begin
      @(posedge clock); #1;
      waits++;
    end
    check_eq({tag, " in_ready"}, 64'(rdy_of(w)), 64'd1);
    if (w == 64) begin
      a64 = a; b64 = b; fs64 = fs; c064 = c0; iv64 = 1'b1;
      q64.push_back(e); t64.push_back(tag);
    end else begin
      a16 = a[15:0]; b16 = b[15:0]; fs16 = fs; c016 = c0; iv16 = 1'b1;
      q16.push_back(e); t16.push_back(tag);
    end
    @(posedge clock); #1;
    // Scramble inputs after accept: the DUT must use the captured copies.
    if (w == 64) begin
      iv64 = 1'b0; a64 = ~a; b64 = {$urandom, $urandom}; fs64 = ~fs; c064 = ~c0;
    end else begin
      iv16 = 1'b0; a16 = ~a[15:0]; b16 = 16'($urandom); fs16 = ~fs; c016 = ~c0;
    end
    lat      = 1;
    busy_bad = 0;
    while (!vld_of(w) && lat < 200) begin
      if (rdy_of(w)) busy_bad++;
      @(posedge clock); #1;
      lat++;
    end
    check_eq({tag, " latency"}, 64'(lat), 64'(exp_lat));
    check_eq({tag, " busy in_ready"}, 64'(busy_bad), 64'd0);
    check_eq({tag, " done in_ready"}, 64'(rdy_of(w)), 64'd0);
  endtask

  always @(negedge clock) begin : mon64
    exp_t  e;
    string t;
    if (!reset && ov64 && ordy64) begin
      if (q64.size() == 0) begin
        check_eq("sb64 underflow", 64'(q64.size()), 64'd1);
      end else begin
        e = q64.pop_front();
        t = t64.pop_front();
        check_eq({t, " F"}, f64, e.f);
        check_eq({t, " status"}, 64'(st64), 64'(e.st));
      end
    end
  end

  always @(negedge clock) begin : mon16
    exp_t  e;
    string t;
    if (!reset && ov16 && ordy16) begin
      if (q16.size() == 0) begin
        check_eq("sb16 underflow", 64'(q16.size()), 64'd1);
      end else begin
        e = q16.pop_front();
        t = t16.pop_front();
        check_eq({t, " F"}, 64'(f16), e.f);
        check_eq({t, " status"}, 64'(st16), 64'(e.st));
      end
    end
  end

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    logic [63:0] f_hold;
    logic [3:0]  st_hold;
    reset = 1'b1;
    iv64 = 1'b0; a64 = '0; b64 = '0; fs64 = '0; c064 = 1'b0; ordy64 = 1'b1;
    iv16 = 1'b0; a16 = '0; b16 = '0; fs16 = '0; c016 = 1'b0; ordy16 = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    check_eq("rst in_ready", 64'(ir64), 64'd1);
    check_eq("rst out_valid", 64'(ov64), 64'd0);
    check_eq("rst F", f64, 64'd0);
    check_eq("rst status", 64'(st64), 64'd0);
    reset = 1'b0;

    issue(64, "add ovf", 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 5'b01000, 1'b0);
    issue(64, "sub zero", 64'd5, 64'd5, 5'b01010, 1'b1);
    issue(64, "mul", 64'hFFFF_FFFF, 64'h1_0000_0001, 5'b11000, 1'b0);
    issue(64, "udiv", 64'd100, 64'd7, 5'b11100, 1'b0);
    issue(64, "udiv0", 64'd1234, 64'd0, 5'b11100, 1'b0);
    issue(64, "lsl", 64'h1, 64'hFFC3, 5'b10000, 1'b0);
    issue(64, "lsr", 64'h8000_0000_0000_0000, 64'd63, 5'b10100, 1'b0);
    issue(64, "lsl fsx", 64'hF0, 64'd4, 5'b10011, 1'b1);
    issue(64, "and ~a", 64'hFF00_FF00_1234_5678, 64'h0F0F_0F0F_FFFF_0000, 5'b00001, 1'b0);
    issue(64, "or ~b", 64'h0, 64'hFFFF_FFFF_0000_0000, 5'b00110, 1'b0);
    issue(64, "xor", 64'hAAAA_5555_AAAA_5555, 64'hFFFF_0000_FFFF_0000, 5'b01100, 1'b0);
    issue(64, "add carry", 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 5'b01000, 1'b1);
    issue(64, "mul wrap", 64'hDEAD_BEEF_0123_4567, 64'hCAFE_F00D_89AB_CDEF, 5'b11011, 1'b0);
    issue(64, "udiv big", 64'hFFFF_FFFF_FFFF_FFFF, 64'h3, 5'b11100, 1'b0);
    for (int i = 0; i < 3; i++) begin
      issue(64, "mul rnd", {$urandom, $urandom}, {32'd0, $urandom}, 5'b11000, 1'b0);
      issue(64, "udiv rnd", {$urandom, $urandom}, {16'd0, 16'($urandom), $urandom}, 5'b11100,
            1'b0);
    end

    // Reset mid-MUL: the iteration is abandoned and nothing reaches the output.
    @(posedge clock); #1;
    a64 = 64'hFFFF_FFFF; b64 = 64'h1_0000_0001; fs64 = 5'b11000; iv64 = 1'b1;
    @(posedge clock); #1;
    iv64 = 1'b0;
    repeat (9) @(posedge clock);
    #1;
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    check_eq("abort in_ready", 64'(ir64), 64'd1);
    check_eq("abort out_valid", 64'(ov64), 64'd0);
    check_eq("abort F", f64, 64'd0);
    check_eq("abort status", 64'(st64), 64'd0);

    // Backpressure: result held in DONE, a pending request is stalled.
    ordy64 = 1'b0;
    issue(64, "bp add", 64'h1234, 64'h4321, 5'b01000, 1'b0);
    f_hold  = f64;
    st_hold = st64;
    a64 = 64'd9; b64 = 64'd3; fs64 = 5'b01000; c064 = 1'b0; iv64 = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clock); #1;
      check_eq("bp F held", f64, f_hold);
      check_eq("bp status held", 64'(st64), 64'(st_hold));
      check_eq("bp out_valid", 64'(ov64), 64'd1);
      check_eq("bp in_ready", 64'(ir64), 64'd0);
    end
    ordy64 = 1'b1;
    @(posedge clock); #1;
    check_eq("bp idle out_valid", 64'(ov64), 64'd0);
    check_eq("bp idle in_ready", 64'(ir64), 64'd1);
    check_eq("bp idle F held", f64, f_hold);
    issue(64, "bp second", 64'd9, 64'd3, 5'b01000, 1'b0);

    issue(16, "w16 add", 64'h7FFF, 64'h1, 5'b01000, 1'b0);
    issue(16, "w16 sub", 64'h0003, 64'h0005, 5'b01010, 1'b1);
    issue(16, "w16 mul", 64'hBEEF, 64'h1234, 5'b11000, 1'b0);
    issue(16, "w16 udiv", 64'hFFFE, 64'h0007, 5'b11100, 1'b0);
    issue(16, "w16 udiv0", 64'h0042, 64'h0000, 5'b11100, 1'b0);
    issue(16, "w16 lsl", 64'h0001, 64'hFFFF, 5'b10000, 1'b0);
    for (int i = 0; i < 3; i++) begin
      issue(16, "w16 mul rnd", 64'($urandom_range(0, 65535)), 64'($urandom_range(0, 65535)),
            5'b11000, 1'b0);
      issue(16, "w16 udiv rnd", 64'($urandom_range(0, 65535)), 64'($urandom_range(1, 300)),
            5'b11100, 1'b0);
    end

    repeat (4) @(posedge clock);
    #1;
    check_eq("sb64 drained", 64'(q64.size()), 64'd0);
    check_eq("sb16 drained", 64'(q16.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
